// File: rtl/lsu_ctrl_if.sv
// Memory-side bus of the load/store unit: request, write lanes, grant and read return.
interface lsu_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: issues one bus transaction per memory op, stalls execute
// until it completes, and merges load data with the ALU writeback path.
module lsu_ctrl_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] size,
  input  logic [1:0] off,
  input  logic [7:0] b0,
  input  logic [7:0] hb,
  input  logic [7:0] wb,
  output logic [7:0] lane_data,
  output logic       lane_be
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    case (size)
      2'b00:   begin lane_data = b0; lane_be = (off == L);       end
      2'b01:   begin lane_data = hb; lane_be = (off[1] == L[1]); end
      default: begin lane_data = wb; lane_be = 1'b1;             end
    endcase
  end
endmodule

module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid_i,
  input  logic        op_we_i,
  input  logic [2:0]  op_funct3_i,
  input  logic [31:0] op_addr_i,
  input  logic [31:0] op_wdata_i,
  input  logic        ex_rd_we_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic [4:0]  ex_rd_addr_i,
  output logic        stall_o,
  output logic        err_o,
  lsu_ctrl_if.master  mem,
  output logic        rd_we_o,
  output logic [31:0] rd_data_o,
  output logic [4:0]  rd_addr_o
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  rd;
  } op_t;

  state_t  state, state_n;
  op_t     op_q;
  logic [CW-1:0] cnt;
  logic    accept, cnt_clr, cnt_inc, mem_req;
  logic    illegal, misal;
  logic [NUM_LANES-1:0][7:0] st_wdata;
  logic [NUM_LANES-1:0]      st_be;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] ld_data;

  // Store lanes are formed from the incoming op so the latched copy is bus-ready.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_ctrl_lane #(.LANE(g)) u_lane (
      .size      (op_funct3_i[1:0]),
      .off       (op_addr_i[1:0]),
      .b0        (op_wdata_i[7:0]),
      .hb        (op_wdata_i[8*(g%2) +: 8]),
      .wb        (op_wdata_i[8*g +: 8]),
      .lane_data (st_wdata[g]),
      .lane_be   (st_be[g])
    );
  end

  always_comb begin
    case (op_funct3_i)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = op_we_i;
      default:                illegal = 1'b1;
    endcase
    misal = (op_funct3_i[1:0] == 2'b01 && op_addr_i[0]) ||
            (op_funct3_i[1:0] == 2'b10 && (op_addr_i[1:0] != 2'b00));
  end

  always_comb begin
    case (op_q.addr[1:0])
      2'd0:    b_sel = mem.mem_rdata_i[7:0];
      2'd1:    b_sel = mem.mem_rdata_i[15:8];
      2'd2:    b_sel = mem.mem_rdata_i[23:16];
      default: b_sel = mem.mem_rdata_i[31:24];
    endcase
    h_sel = op_q.addr[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (op_q.funct3)
      3'b000:  ld_data = {{24{b_sel[7]}}, b_sel};
      3'b001:  ld_data = {{16{h_sel[15]}}, h_sel};
      3'b100:  ld_data = {24'b0, b_sel};
      3'b101:  ld_data = {16'b0, h_sel};
      default: ld_data = mem.mem_rdata_i;
    endcase
  end

  always_comb begin
    state_n   = state;
    stall_o   = 1'b0;
    err_o     = 1'b0;
    rd_we_o   = 1'b0;
    rd_data_o = ex_rd_data_i;
    rd_addr_o = ex_rd_addr_i;
    mem_req   = 1'b0;
    accept    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (!op_valid_i) begin
          rd_we_o = ex_rd_we_i;
        end else if (illegal || misal) begin
          err_o = 1'b1;
        end else begin
          accept  = 1'b1;
          stall_o = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        stall_o   = 1'b1;
        rd_data_o = ld_data;
        rd_addr_o = op_q.rd;
        if (mem.mem_gnt_i) begin
          cnt_clr = 1'b1;
          if (op_q.we) begin
            stall_o = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        stall_o   = 1'b1;
        rd_data_o = ld_data;
        rd_addr_o = op_q.rd;
        // Returning data wins over an expiring timeout in the same cycle.
        if (mem.mem_rvalid_i) begin
          rd_we_o = 1'b1;
          stall_o = 1'b0;
          state_n = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_o   = 1'b1;
          stall_o = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (accept) begin
        op_q.we     <= op_we_i;
        op_q.funct3 <= op_funct3_i;
        op_q.addr   <= op_addr_i;
        op_q.wdata  <= st_wdata;
        op_q.be     <= op_we_i ? st_be : 4'hF;
        op_q.rd     <= ex_rd_addr_i;
      end
    end
  end

  assign mem.mem_req_o   = mem_req;
  assign mem.mem_we_o    = mem_req & op_q.we;
  assign mem.mem_addr_o  = {op_q.addr[31:2], 2'b00};
  assign mem.mem_wdata_o = op_q.wdata;
  assign mem.mem_be_o    = op_q.be;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases with literal expectations, then random ops
// checked cycle by cycle against a transaction-level model.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_we;
  logic [2:0]  op_f3;
  logic [31:0] op_addr, op_wdata;
  logic        ex_we;
  logic [31:0] ex_data;
  logic [4:0]  ex_addr;
  logic        stall, err, rd_we;
  logic [31:0] rd_data;
  logic [4:0]  rd_addr;

  lsu_ctrl_if m();

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid_i   (op_valid),
    .op_we_i      (op_we),
    .op_funct3_i  (op_f3),
    .op_addr_i    (op_addr),
    .op_wdata_i   (op_wdata),
    .ex_rd_we_i   (ex_we),
    .ex_rd_data_i (ex_data),
    .ex_rd_addr_i (ex_addr),
    .stall_o      (stall),
    .err_o        (err),
    .mem          (m),
    .rd_we_o      (rd_we),
    .rd_data_o    (rd_data),
    .rd_addr_o    (rd_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Expected outputs for the current cycle; e_schk/e_bus/e_wchk/e_rd gate optional fields.
  logic        e_stall, e_schk, e_err, e_req, e_we, e_bus, e_wchk, e_rdwe, e_rd;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic [3:0]  e_be;
  logic [4:0]  e_rdaddr;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (e_schk) cmp("stall_o", {31'b0, stall}, {31'b0, e_stall});
      cmp("err_o",     {31'b0, err},        {31'b0, e_err});
      cmp("mem_req_o", {31'b0, m.mem_req_o}, {31'b0, e_req});
      cmp("mem_we_o",  {31'b0, m.mem_we_o},  {31'b0, e_we});
      if (e_bus) begin
        cmp("mem_addr_o", m.mem_addr_o, e_addr);
        cmp("mem_be_o",   {28'b0, m.mem_be_o}, {28'b0, e_be});
        if (e_wchk) cmp("mem_wdata_o", m.mem_wdata_o, e_wd);
      end
      cmp("rd_we_o", {31'b0, rd_we}, {31'b0, e_rdwe});
      if (e_rd) begin
        cmp("rd_data_o", rd_data, e_rdata);
        cmp("rd_addr_o", {27'b0, rd_addr}, {27'b0, e_rdaddr});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic f_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3 > 3'd2)) return 1'b1;
    sz = (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
    return (a % 32'(sz)) != 0;
  endfunction

  function automatic logic [31:0] f_wd(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return 32'(w[7:0]) * 32'h0101_0101;
      3'd1:    return 32'(w[15:0]) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'hF;
    case (f3)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return 4'b0011 << a[1:0];
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    longint v;
    int off;
    off = int'(a[1:0]);
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((d >> (8 * off)) & 32'hFF);
        if (f3 == 3'd0 && v > 127) v -= 256;
      end
      3'd1, 3'd5: begin
        v = longint'((d >> (8 * off)) & 32'hFFFF);
        if (f3 == 3'd1 && v > 32767) v -= 65536;
      end
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ex();
    ex_we   = 1'($urandom);
    ex_data = $urandom;
    ex_addr = 5'($urandom);
  endtask

  task automatic exp_clear();
    e_stall = 1'b0; e_schk = 1'b1; e_err = 1'b0; e_req = 1'b0; e_we = 1'b0;
    e_bus = 1'b0; e_wchk = 1'b0; e_rdwe = 1'b0; e_rd = 1'b0;
    e_addr = '0; e_wd = '0; e_be = '0; e_rdata = '0; e_rdaddr = '0;
  endtask

  task automatic exp_idle();
    exp_clear();
    e_rdwe = ex_we; e_rd = 1'b1; e_rdata = ex_data; e_rdaddr = ex_addr;
  endtask

  task automatic exp_reset_bus();
    e_bus = 1'b1; e_wchk = 1'b1; e_addr = '0; e_wd = '0; e_be = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      op_valid = 1'b0; op_we = 1'($urandom); op_f3 = 3'($urandom);
      op_addr = $urandom; op_wdata = $urandom;
      rand_ex();
      m.mem_gnt_i = 1'($urandom); m.mem_rvalid_i = 1'($urandom); m.mem_rdata_i = $urandom;
      exp_idle();
      tick();
    end
  endtask

  // One full memory op; pin=1 replaces model results with hand-computed literals.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input int gdly, input int rdly, input logic [31:0] rdata,
                       input logic pin, input logic [31:0] p_ld, input logic [31:0] p_wd,
                       input logic [31:0] p_addr, input logic [3:0] p_be);
    logic        bad;
    logic [31:0] x_addr, x_wd, x_ld;
    logic [3:0]  x_be;
    bad    = f_bad(we, f3, addr);
    x_addr = pin ? p_addr : (addr & ~32'd3);
    x_wd   = pin ? p_wd   : f_wd(f3, wdata);
    x_be   = pin ? p_be   : f_be(we, f3, addr);
    x_ld   = pin ? p_ld   : f_ld(f3, addr, rdata);

    op_valid = 1'b1; op_we = we; op_f3 = f3; op_addr = addr; op_wdata = wdata;
    ex_we = 1'($urandom); ex_data = $urandom; ex_addr = rd;
    m.mem_gnt_i = 1'($urandom); m.mem_rvalid_i = 1'($urandom); m.mem_rdata_i = $urandom;
    exp_clear();
    e_stall = !bad; e_err = bad;
    tick();
    if (bad) return;

    for (int k = 0; k <= gdly; k++) begin
      m.mem_gnt_i = (k == gdly);
      m.mem_rvalid_i = ($urandom_range(0, 3) == 0);
      m.mem_rdata_i = $urandom;
      rand_ex();
      exp_clear();
      e_req = 1'b1; e_we = we; e_bus = 1'b1; e_wchk = we;
      e_addr = x_addr; e_wd = x_wd; e_be = x_be;
      e_stall = !(m.mem_gnt_i && we);
      tick();
    end
    if (we) return;

    for (int k = 0; k < TO; k++) begin
      m.mem_rvalid_i = (k == rdly);
      m.mem_rdata_i  = m.mem_rvalid_i ? rdata : $urandom;
      m.mem_gnt_i    = 1'($urandom);
      rand_ex();
      exp_clear();
      if (m.mem_rvalid_i) begin
        e_rdwe = 1'b1; e_rd = 1'b1; e_rdata = x_ld; e_rdaddr = rd; e_stall = 1'b0;
      end else if (k == TO - 1) begin
        e_err = 1'b1; e_schk = 1'b0;
      end else begin
        e_stall = 1'b1;
      end
      tick();
      if (k == rdly) break;
    end
  endtask

  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  int          r_sel, r_gd, r_rd;
  logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_we = 1'b0; op_f3 = '0; op_addr = '0; op_wdata = '0;
    ex_we = 1'b0; ex_data = 32'h55; ex_addr = 5'd3;
    m.mem_gnt_i = 1'b0; m.mem_rvalid_i = 1'b0; m.mem_rdata_i = '0;
    #1;
    exp_idle(); exp_reset_bus();
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // ALU writeback passthrough in IDLE
    op_valid = 1'b0; ex_we = 1'b1; ex_addr = 5'd5; ex_data = 32'h1234;
    exp_clear(); e_rdwe = 1'b1; e_rd = 1'b1; e_rdata = 32'h0000_1234; e_rdaddr = 5'd5;
    tick();

    // LB 0x103 -> 0xFFFFFF80
    do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80FF_1234,
          1'b1, 32'hFFFF_FF80, 32'h0, 32'h100, 4'hF);
    // SH 0x202, grant after 4 waiting cycles
    do_op(1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 5'd0, 4, 0, 32'h0,
          1'b1, 32'h0, 32'hABCD_ABCD, 32'h200, 4'b1100);
    // LW misaligned
    do_op(1'b0, 3'd2, 32'h001, 32'h0, 5'd1, 0, 0, 32'h0,
          1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    // LHU timeout then immediate back-to-back LW
    do_op(1'b0, 3'd5, 32'h002, 32'h0, 5'd2, 0, 99, 32'h0,
          1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    do_op(1'b0, 3'd2, 32'h010, 32'h0, 5'd4, 0, 1, 32'hCAFE_F00D,
          1'b1, 32'hCAFE_F00D, 32'h0, 32'h010, 4'hF);
    // SB 0x7 literal lanes
    do_op(1'b1, 3'd0, 32'h007, 32'h0000_005A, 5'd0, 1, 0, 32'h0,
          1'b1, 32'h0, 32'h5A5A_5A5A, 32'h004, 4'b1000);
    idle(1);

    // Reset pulse while waiting for read data
    op_valid = 1'b1; op_we = 1'b0; op_f3 = 3'd2; op_addr = 32'h40; op_wdata = '0;
    ex_we = 1'b0; ex_addr = 5'd9; m.mem_gnt_i = 1'b0; m.mem_rvalid_i = 1'b0;
    exp_clear(); e_stall = 1'b1;
    tick();
    m.mem_gnt_i = 1'b1;
    exp_clear(); e_req = 1'b1; e_bus = 1'b1; e_addr = 32'h40; e_be = 4'hF; e_stall = 1'b1;
    tick();
    m.mem_gnt_i = 1'b0;
    exp_clear(); e_stall = 1'b1;
    tick();
    op_valid = 1'b0; ex_we = 1'b0; rst_n = 1'b0;
    exp_idle(); exp_reset_bus();
    tick();
    rst_n = 1'b1; m.mem_rvalid_i = 1'b1; m.mem_rdata_i = 32'hDEAD_BEEF;
    exp_idle(); exp_reset_bus();
    tick();
    m.mem_rvalid_i = 1'b0;
    exp_idle(); exp_reset_bus();
    tick();

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      r_we   = 1'($urandom);
      r_addr = {20'($urandom), 12'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        r_f3 = legal_f3[$urandom_range(0, 4)];
        if (r_we) r_f3 = r_f3 & 3'b011;
        if ($urandom_range(0, 3) != 0) begin
          if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
          else if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
        end
      end else begin
        r_f3 = 3'($urandom);
      end
      r_gd  = $urandom_range(0, 3);
      r_sel = $urandom_range(0, 9);
      r_rd  = (r_sel == 9) ? 99 : (r_sel == 8) ? TO - 1 : $urandom_range(0, 2);
      do_op(r_we, r_f3, r_addr, $urandom, 5'($urandom), r_gd, r_rd, $urandom,
            1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for mem_rvalid_i before aborting a load.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op_valid_i  in  1  memory operation present from execute stage.
REQ-005 op_we_i  in  1  1 = store, 0 = load.
REQ-006 op_funct3_i  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 op_addr_i  in  32  effective byte address.
REQ-008 op_wdata_i  in  32  store data in low bits.
REQ-009 ex_rd_we_i, ex_rd_data_i, ex_rd_addr_i  in  1/32/5  non-memory writeback from execute.
REQ-010 stall_o  out  1  holds execute stage and its outputs stable.
REQ-011 err_o  out  1  one-cycle pulse: misaligned, illegal funct3 or timeout.
REQ-012 mem_req_o, mem_we_o  out  1/1  bus request and write strobe.
REQ-013 mem_addr_o  out  32  word-aligned address, low 2 bits zero.
REQ-014 mem_wdata_o, mem_be_o  out  32/4  lane-replicated write data and byte enables.
REQ-015 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1/1/32  grant, read-data valid, read word.
REQ-016 rd_we_o, rd_data_o, rd_addr_o  out  1/32/5  writeback to ls_wb stage.

Function
REQ-017 States IDLE, REQ, WAIT; no other states reachable.
REQ-018 IDLE with op_valid_i=0: rd_* = ex_rd_* combinationally; stall_o=0.
REQ-019 IDLE with op_valid_i=1 and legal aligned op: latch op and rd address; go to REQ; stall_o=1 that cycle; rd_we_o=0.
REQ-020 Misalignment: H/HU with addr[0]=1, W with addr[1:0]!=00; illegal funct3: 011, 110, 111, or 1xx when op_we_i=1.
REQ-021 Misaligned or illegal op in IDLE: err_o=1 that cycle, no bus request, rd_we_o=0, stall_o=0, stay IDLE.
REQ-022 REQ: mem_req_o=1 with latched mem_we_o/addr/wdata/be held stable until mem_gnt_i=1.
REQ-023 REQ with gnt, store: go IDLE; stall_o=0 in that cycle; rd_we_o=0.
REQ-024 REQ with gnt, load: go to WAIT, clear timeout counter.
REQ-025 WAIT with mem_rvalid_i=1: rd_we_o=1, rd_data_o=extracted data, rd_addr_o=latched rd address; stall_o=0; go IDLE.
REQ-026 Extraction: lane chosen by addr[1:0] (B) or addr[1] (H); B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-027 Store lanes: B -> wdata[7:0] replicated x4, be=0001<<addr[1:0]; H -> wdata[15:0] replicated x2, be=0011<<addr[1:0]; W -> be=1111.
REQ-028 Loads drive mem_be_o=1111 and mem_we_o=0.
REQ-029 Timeout counter increments each WAIT cycle without rvalid; when it reaches TIMEOUT: err_o=1, rd_we_o=0, go IDLE.
REQ-030 rvalid outside WAIT is ignored; rd_we_o=0 in every REQ/WAIT cycle except the completion of REQ-025.
REQ-031 rvalid arriving in the same cycle the counter reaches TIMEOUT takes priority: data returned, err_o=0.
REQ-032 Back-to-back: a new op presented in the cycle after completion is accepted with no idle bubble.

Reset
REQ-033 rst_n low: state IDLE, counter 0, latched op cleared; mem_req_o=0, err_o=0, rd_we_o=0, stall_o=0 (when op_valid_i=0), mem_addr_o/wdata_o/be_o=0.
REQ-034 Reset during REQ or WAIT abandons the transaction; no writeback or error is produced afterwards.

Verification
REQ-035 LB at addr 0x103, rdata 0x80FF_1234, gnt and rvalid one cycle each -> rd_we_o=1, rd_data_o=0xFFFF_FF80 three cycles after issue.
REQ-036 SH addr 0x202, wdata 0x0000_ABCD, gnt delayed 4 cycles -> mem_req_o high 5 cycles, wdata 0xABCD_ABCD, be 1100, addr 0x200.
REQ-037 LW at addr 0x001 -> err_o one cycle, mem_req_o stays 0, rd_we_o 0.
REQ-038 LHU addr 0x02, TIMEOUT=4, no rvalid -> err_o after 4 WAIT cycles, return to IDLE, next op accepted.
REQ-039 rst_n low for one cycle during WAIT, then rvalid -> no rd_we_o pulse; all outputs at reset values.
REQ-040 ALU passthrough ex_rd_we=1, addr 5, data 0x1234 in IDLE -> rd_* mirrors it in the same cycle with stall_o=0.
